// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with valid/ack data memory handshake
module mem_stage_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  op_store,
    input  logic [1:0]            op_size,
    input  logic                  op_signed,
    input  logic [ADDR_W-1:0]     op_addr,
    input  logic [DATA_W-1:0]     op_wdata,
    input  logic [3:0]            op_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  wb_valid,
    output logic [3:0]            wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  stall,
    output logic                  fault,
    output logic [1:0]            fault_code
);
    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam logic [6:0] DW7     = 7'(DATA_W);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    logic [7:0]          wait_cnt;
    logic                lat_store;
    logic                lat_signed;
    logic [1:0]          lat_size;
    logic [LANE_W-1:0]   lat_lane;
    logic [3:0]          lat_rd;

    logic                bad_op;
    logic [LANE_W-1:0]   req_lane;
    logic [BE_W-1:0]     be_mask;
    logic [BE_W-1:0]     be_next;
    logic [DATA_W-1:0]   wdata_rep;
    logic [DATA_W-1:0]   ld_shifted;
    logic [DATA_W-1:0]   ld_shl;
    logic [DATA_W-1:0]   ld_ext;
    logic [6:0]          ext_sh;

    assign op_ready = rst_n && (state == IDLE);
    assign stall    = rst_n && (state == ACCESS);
    assign req_lane = op_addr[LANE_W-1:0];

    always_comb begin
        bad_op = 1'b0;
        case (op_size)
            2'b00: bad_op = 1'b0;
            2'b01: bad_op = op_addr[0];
            2'b10: bad_op = |op_addr[1:0];
            2'b11: bad_op = (DATA_W == 32) || (|op_addr[2:0]);
            default: bad_op = 1'b1;
        endcase
    end

    always_comb begin
        be_mask   = '0;
        wdata_rep = '0;
        case (op_size)
            2'b00: begin
                be_mask   = BE_W'(1);
                wdata_rep = {BE_W{op_wdata[7:0]}};
            end
            2'b01: begin
                be_mask   = BE_W'(3);
                wdata_rep = {(BE_W/2){op_wdata[15:0]}};
            end
            2'b10: begin
                be_mask   = BE_W'(15);
                wdata_rep = {(DATA_W/32){op_wdata[31:0]}};
            end
            default: begin
                be_mask   = '1;
                wdata_rep = op_wdata;
            end
        endcase
        be_next = be_mask << req_lane;
    end

    // Extend by parking the field at the MSB and shifting back down (arithmetic or logical).
    always_comb begin
        ld_shifted = mem_rdata >> {lat_lane, 3'b000};
        case (lat_size)
            2'b00:   ext_sh = DW7 - 7'd8;
            2'b01:   ext_sh = DW7 - 7'd16;
            2'b10:   ext_sh = DW7 - 7'd32;
            default: ext_sh = 7'd0;
        endcase
        ld_shl = ld_shifted << ext_sh;
        if (lat_signed) begin
            ld_ext = $signed(ld_shl) >>> ext_sh;
        end else begin
            ld_ext = ld_shl >> ext_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lat_store  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= '0;
            lat_lane   <= '0;
            lat_rd     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            wb_valid   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (bad_op) begin
                            fault      <= 1'b1;
                            fault_code <= 2'b01;
                        end else begin
                            state      <= ACCESS;
                            wait_cnt   <= '0;
                            lat_store  <= op_store;
                            lat_signed <= op_signed;
                            lat_size   <= op_size;
                            lat_lane   <= req_lane;
                            lat_rd     <= op_rd;
                            mem_req    <= 1'b1;
                            mem_we     <= op_store;
                            mem_addr   <= {op_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            mem_be     <= be_next;
                            mem_wdata  <= wdata_rep;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the final wait cycle takes priority over the timeout.
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!lat_store) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= lat_rd;
                            wb_data  <= ld_ext;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
